ram_stream_ctrl: RTL and testbench
==================================

Name: ram_stream_ctrl

Overview:
Sequencer that sits directly upstream of the 512x8 single-port synchronous microcode RAM and owns its address, data-in and write-enable pins. In load mode it writes a valid/ready byte stream into consecutive RAM locations. In dump mode it reads consecutive locations and presents them as a valid/ready byte stream, absorbing the RAM's one-cycle read latency. Used for program download and readback/verify.

Parameters:
ADDR_W, 9, RAM address width; depth = 2**ADDR_W.
DATA_W, 8, RAM word width.

Ports:
CLOCK  in  1  system clock; all state updates on the rising edge.
RESET  in  1  asynchronous, active-high reset.
START_LOAD  in  1  one-cycle request to begin a load; sampled only in IDLE.
START_DUMP  in  1  one-cycle request to begin a dump; sampled only in IDLE.
BASE_ADDR  in  ADDR_W  first RAM address, sampled with the start request.
COUNT  in  ADDR_W  transfer length minus one (0 gives 1 byte, 511 gives 512), sampled with the start request.
IN_DATA  in  DATA_W  load stream data.
IN_VALID  in  1  load stream valid.
IN_READY  out  1  load stream ready.
OUT_DATA  out  DATA_W  dump stream data.
OUT_VALID  out  1  dump stream valid.
OUT_READY  in  1  dump stream ready.
RAM_ADDRESS  out  ADDR_W  to RAM ADDRESS; registered.
RAM_DATAIN  out  DATA_W  to RAM DATAIN; registered.
RAM_WE  out  1  to RAM WE; registered.
RAM_DATAOUT  in  DATA_W  from RAM DATAOUT; valid the cycle after the address is presented.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - State goes to IDLE.
  - All outputs are 0: RAM_WE, RAM_ADDRESS, RAM_DATAIN, OUT_DATA, OUT_VALID, IN_READY, BUSY, DONE.
  - A partial load leaves the RAM partially written; no rollback.
- States: IDLE, LOAD, DUMP_RD, DUMP_WAIT, DUMP_OUT.
- IDLE:
  - START_LOAD wins if both starts are high; the block goes to LOAD.
  - START_DUMP alone: RAM_ADDRESS <= BASE_ADDR and the block goes to DUMP_RD.
  - Both starts latch addr = BASE_ADDR and remaining = COUNT.
  - Starts asserted outside IDLE are ignored.
- LOAD:
  - IN_READY = 1 (combinational from state).
  - Each cycle with IN_VALID && IN_READY, on the next edge: RAM_WE <= 1, RAM_ADDRESS <= addr, RAM_DATAIN <= IN_DATA.
  - Otherwise RAM_WE <= 0.
  - Full throughput is 1 byte per cycle.
  - After the beat accepted with remaining == 0, the block goes to IDLE and DONE pulses with the final RAM_WE cycle.
  - IN_READY drops as soon as the state leaves LOAD.
- DUMP_RD: RAM_ADDRESS holds addr; RAM_WE = 0; next state is DUMP_WAIT.
- DUMP_WAIT: OUT_DATA <= RAM_DATAOUT at the end of the cycle; next state is DUMP_OUT.
- DUMP_OUT:
  - OUT_VALID = 1; OUT_DATA is held stable until OUT_READY.
  - On the handshake, if remaining == 0: go to IDLE and pulse DONE.
  - Otherwise: addr += 1, RAM_ADDRESS <= addr+1, remaining -= 1, next state is DUMP_RD.
  - Minimum is 3 cycles per dumped byte.
- Address wrap: addr increments modulo 2**ADDR_W (511 -> 0). No error is flagged.
- RAM_WE is never asserted outside LOAD.
- RAM_ADDRESS changes only on write beats or on entry to DUMP_RD.

Decomposition:
- Shared package holds:
  - the state encoding constants (ST_IDLE=0 .. ST_DUMP_OUT=4);
  - RAM_DEPTH = 512, ADDR_W = 9, DATA_W = 8 defaults, shared with the RAM wrapper.
- No sub-module. Address and remaining counters stay inline; the datapath is too small to justify a split.

Test Plan:
- Load 4 bytes from BASE_ADDR=0x010, COUNT=3, data A1,B2,C3,D4 back-to-back -> RAM_WE high 4 consecutive cycles at addresses 0x010..0x013; DONE pulses once; BUSY falls; RAM model holds A1..D4.
- Dump the same region with OUT_READY held 1 -> OUT_DATA A1,B2,C3,D4, each with OUT_VALID for one cycle, 3-cycle spacing; DONE after D4.
- Dump with OUT_READY low for 5 cycles on the second byte -> OUT_VALID and OUT_DATA=B2 held stable 6 cycles; no extra RAM reads; order preserved.
- Wrap: load BASE_ADDR=0x1FE, COUNT=3, data 11,22,33,44 -> writes to 0x1FE, 0x1FF, 0x000, 0x001; dump reads back 11,22,33,44.
- START_LOAD and START_DUMP asserted together in IDLE -> LOAD entered; START_DUMP asserted mid-load is ignored; IN_VALID gaps insert RAM_WE=0 cycles without skipping addresses.
- RESET pulsed asynchronously after the 2nd of 4 load beats -> all outputs 0 immediately; IN_READY=0; a following START_DUMP of the same region returns the 2 written bytes plus the prior RAM contents.

Source files
------------

// File: rtl/ram_stream_ctrl_pkg.sv
// Shared constants and state encoding for the microcode RAM stream sequencer.
// RAM geometry defaults are shared with the RAM wrapper.
package ram_stream_ctrl_pkg;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_DUMP_RD   = 3'd2,
    ST_DUMP_WAIT = 3'd3,
    ST_DUMP_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_stream_ctrl.sv
// Load/dump sequencer owning the address, data-in and write-enable pins of a
// single-port synchronous RAM with one-cycle read latency.
module ram_stream_ctrl
  import ram_stream_ctrl_pkg::*;
#(
  parameter int ADDR_W = ram_stream_ctrl_pkg::ADDR_W,
  parameter int DATA_W = ram_stream_ctrl_pkg::DATA_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START_LOAD,
  input  logic              START_DUMP,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W-1:0] COUNT,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] RAM_ADDRESS,
  output logic [DATA_W-1:0] RAM_DATAIN,
  output logic              RAM_WE,
  input  logic [DATA_W-1:0] RAM_DATAOUT,
  output logic              BUSY,
  output logic              DONE
);

  state_t              state_r, next_state_s;
  logic [ADDR_W-1:0]   addr_r, remain_r, addr_inc_s;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]   ram_din_r, out_data_r;
  logic                we_r, done_r, busy_r, in_ready_r, out_valid_r;
  logic                last_s, load_start_s, dump_start_s, wr_beat_s, dump_next_s, done_s;

  // Address wraps naturally modulo the RAM depth through truncation.
  assign addr_inc_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign last_s     = (remain_r == {ADDR_W{1'b0}});

  // Next-state and transfer strobes.
  always_comb begin
    next_state_s = state_r;
    load_start_s = 1'b0;
    dump_start_s = 1'b0;
    wr_beat_s    = 1'b0;
    dump_next_s  = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START_LOAD) begin
          load_start_s = 1'b1;
          next_state_s = ST_LOAD;
        end else if (START_DUMP) begin
          dump_start_s = 1'b1;
          next_state_s = ST_DUMP_RD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (IN_VALID) begin
          wr_beat_s = 1'b1;
          if (last_s) begin
            done_s       = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_DUMP_RD:   next_state_s = ST_DUMP_WAIT;
      ST_DUMP_WAIT: next_state_s = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (OUT_READY) begin
          if (last_s) begin
            done_s       = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            dump_next_s  = 1'b1;
            next_state_s = ST_DUMP_RD;
          end
        end else begin
          next_state_s = ST_DUMP_OUT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and state-decoded status flags, registered from next state.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      we_r        <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != ST_IDLE);
      in_ready_r  <= (next_state_s == ST_LOAD);
      out_valid_r <= (next_state_s == ST_DUMP_OUT);
      done_r      <= done_s;
      we_r        <= wr_beat_s;
    end
  end

  // Address/length counters and the registered RAM and stream datapath.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      addr_r     <= {ADDR_W{1'b0}};
      remain_r   <= {ADDR_W{1'b0}};
      ram_addr_r <= {ADDR_W{1'b0}};
      ram_din_r  <= {DATA_W{1'b0}};
      out_data_r <= {DATA_W{1'b0}};
    end else begin
      if (load_start_s || dump_start_s) begin
        addr_r   <= BASE_ADDR;
        remain_r <= COUNT;
      end else if ((wr_beat_s && !last_s) || dump_next_s) begin
        addr_r   <= addr_inc_s;
        remain_r <= remain_r - {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      // RAM address moves only on write beats or when a dump read is issued.
      if (dump_start_s) begin
        ram_addr_r <= BASE_ADDR;
      end else if (wr_beat_s) begin
        ram_addr_r <= addr_r;
      end else if (dump_next_s) begin
        ram_addr_r <= addr_inc_s;
      end
      if (wr_beat_s) begin
        ram_din_r <= IN_DATA;
      end
      if (state_r == ST_DUMP_WAIT) begin
        out_data_r <= RAM_DATAOUT;
      end
    end
  end

  assign IN_READY    = in_ready_r;
  assign OUT_VALID   = out_valid_r;
  assign OUT_DATA    = out_data_r;
  assign RAM_ADDRESS = ram_addr_r;
  assign RAM_DATAIN  = ram_din_r;
  assign RAM_WE      = we_r;
  assign BUSY        = busy_r;
  assign DONE        = done_r;

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Randomized self-checking bench for ram_stream_ctrl with a behavioural RAM,
// expected-write and expected-output queues derived from transfer parameters.
module tb_ram_stream_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       START_LOAD = 1'b0, START_DUMP = 1'b0;
  logic [8:0] BASE_ADDR = 9'd0, COUNT = 9'd0;
  logic [7:0] IN_DATA = 8'd0;
  logic       IN_VALID = 1'b0, IN_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID, OUT_READY = 1'b0;
  logic [8:0] RAM_ADDRESS;
  logic [7:0] RAM_DATAIN, RAM_DATAOUT;
  logic       RAM_WE, BUSY, DONE;

  ram_stream_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET), .START_LOAD(START_LOAD), .START_DUMP(START_DUMP),
    .BASE_ADDR(BASE_ADDR), .COUNT(COUNT), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATAIN(RAM_DATAIN), .RAM_WE(RAM_WE),
    .RAM_DATAOUT(RAM_DATAOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed { logic [8:0] a; logic [7:0] d; } wr_t;

  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  logic [7:0] load_data [512];
  wr_t        exp_wr[$];
  logic [7:0] exp_out[$];
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, out_beats = 0, cyc = 0, last_cyc = 0, dump_beats0 = 0;
  int mode = 0;
  bit spacing_on = 1'b0, stall_prev = 1'b0;
  logic [7:0] stall_data = 8'd0;
  wr_t w;

  // Synchronous single-port RAM, read-first, one-cycle read latency.
  always @(posedge CLOCK) begin
    if (RAM_WE) mem[RAM_ADDRESS] <= RAM_DATAIN;
    RAM_DATAOUT <= mem[RAM_ADDRESS];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: write beats, dump beats, stall stability, spacing and DONE pulses.
  always @(negedge CLOCK) begin
    cyc++;
    if (!RESET) begin
      if (RAM_WE) begin
        if (exp_wr.size() == 0) check("spurious_we", 32'(RAM_WE), 32'(0));
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(RAM_ADDRESS), 32'(w.a));
          check("wr_data", 32'(RAM_DATAIN), 32'(w.d));
        end
      end
      if (stall_prev) begin
        check("hold_valid", 32'(OUT_VALID), 32'(1));
        check("hold_data", 32'(OUT_DATA), 32'(stall_data));
      end
      stall_prev = OUT_VALID && !OUT_READY;
      stall_data = OUT_DATA;
      if (OUT_VALID && OUT_READY) begin
        if (exp_out.size() == 0) check("spurious_out", 32'(1), 32'(0));
        else check("out_data", 32'(OUT_DATA), 32'(exp_out.pop_front()));
        if (spacing_on && out_beats > dump_beats0) check("spacing", 32'(cyc - last_cyc), 32'(3));
        last_cyc = cyc;
        out_beats++;
      end
      if (DONE) begin
        done_cnt++;
        if (mode == 1) check("done_with_we", 32'(RAM_WE), 32'(1));
        if (mode == 2) check("done_no_valid", 32'(OUT_VALID), 32'(0));
      end
    end
  end

  task automatic do_load(input logic [8:0] base, input logic [8:0] cnt, input int gap_pct,
                         input bit both, input int abort_after);
    int n = int'(cnt) + 1;
    int i = 0;
    int guard = 0;
    int d0 = done_cnt;
    logic [8:0] a;
    mode = 1;
    START_LOAD = 1'b1; START_DUMP = both; BASE_ADDR = base; COUNT = cnt;
    @(posedge CLOCK); #1;
    START_LOAD = 1'b0; START_DUMP = 1'b0;
    while (i < n && guard < 3000) begin
      IN_VALID   = ($urandom_range(0, 99) >= gap_pct);
      IN_DATA    = load_data[i];
      START_DUMP = both && (i == 1);
      if (IN_VALID && IN_READY) begin
        a = base + 9'(i);
        exp_wr.push_back('{a: a, d: load_data[i]});
        ref_mem[a] = load_data[i];
        i++;
      end
      @(posedge CLOCK); #1;
      guard++;
      if (abort_after > 0 && i == abort_after) break;
    end
    IN_VALID = 1'b0; START_DUMP = 1'b0;
    if (abort_after > 0) begin
      @(posedge CLOCK); #2;
      RESET = 1'b1;
      #1;
      check("rst_outs", 32'({RAM_WE, RAM_ADDRESS, RAM_DATAIN, OUT_DATA, OUT_VALID, IN_READY, BUSY, DONE}), 32'(0));
      #4;
      RESET = 1'b0;
      check("rst_writes_seen", 32'(exp_wr.size()), 32'(0));
    end else begin
      check("load_beats", 32'(i), 32'(n));
      @(posedge CLOCK); #1;
      check("load_done", 32'(done_cnt - d0), 32'(1));
      check("load_writes_left", 32'(exp_wr.size()), 32'(0));
      check("load_idle", 32'({BUSY, IN_READY}), 32'(0));
    end
    mode = 0;
  endtask

  task automatic do_dump(input logic [8:0] base, input logic [8:0] cnt, input int rmode);
    int n = int'(cnt) + 1;
    int guard = 0;
    int hold = 0;
    int d0 = done_cnt;
    logic [8:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + 9'(k);
      exp_out.push_back(ref_mem[a]);
    end
    mode = 2;
    dump_beats0 = out_beats;
    spacing_on = (rmode == 0);
    START_DUMP = 1'b1; BASE_ADDR = base; COUNT = cnt;
    @(posedge CLOCK); #1;
    START_DUMP = 1'b0;
    while (done_cnt == d0 && guard < 5000) begin
      case (rmode)
        0: OUT_READY = 1'b1;
        1: OUT_READY = 1'($urandom_range(0, 1));
        default: begin
          OUT_READY = !(OUT_VALID && (out_beats - dump_beats0 == 1) && hold < 5);
          if (OUT_VALID && (out_beats - dump_beats0 == 1)) hold++;
        end
      endcase
      @(posedge CLOCK); #1;
      guard++;
    end
    OUT_READY = 1'b0;
    spacing_on = 1'b0;
    check("dump_done", 32'(done_cnt - d0), 32'(1));
    check("dump_left", 32'(exp_out.size()), 32'(0));
    check("dump_idle", 32'({BUSY, OUT_VALID}), 32'(0));
    if (rmode == 2) check("stall_cycles", 32'(hold), 32'(6));
    mode = 0;
  endtask

  initial begin
    logic [8:0] base, cnt;
    for (int k = 0; k < 512; k++) begin
      mem[k] = 8'($urandom);
      ref_mem[k] = mem[k];
    end
    #3;
    check("reset_outs", 32'({RAM_WE, RAM_ADDRESS, RAM_DATAIN, OUT_DATA, OUT_VALID, IN_READY, BUSY, DONE}), 32'(0));
    #9;
    RESET = 1'b0;
    @(posedge CLOCK); #1;

    load_data[0] = 8'hA1; load_data[1] = 8'hB2; load_data[2] = 8'hC3; load_data[3] = 8'hD4;
    do_load(9'h010, 9'd3, 0, 1'b0, 0);
    for (int k = 0; k < 4; k++) check("ram_content", 32'(mem[16 + k]), 32'(load_data[k]));
    do_dump(9'h010, 9'd3, 0);
    do_dump(9'h010, 9'd3, 2);

    load_data[0] = 8'h11; load_data[1] = 8'h22; load_data[2] = 8'h33; load_data[3] = 8'h44;
    do_load(9'h1FE, 9'd3, 0, 1'b0, 0);
    do_dump(9'h1FE, 9'd3, 0);

    for (int k = 0; k < 6; k++) load_data[k] = 8'($urandom);
    do_load(9'h080, 9'd5, 40, 1'b1, 0);
    do_dump(9'h080, 9'd5, 1);

    load_data[0] = 8'h5A;
    do_load(9'h1FF, 9'd0, 0, 1'b0, 0);
    do_dump(9'h1FF, 9'd0, 0);

    for (int k = 0; k < 4; k++) load_data[k] = 8'($urandom);
    do_load(9'h040, 9'd3, 0, 1'b0, 2);
    do_dump(9'h040, 9'd3, 1);

    for (int t = 0; t < 10; t++) begin
      base = 9'($urandom_range(0, 511));
      cnt  = 9'($urandom_range(0, 12));
      for (int k = 0; k <= int'(cnt); k++) load_data[k] = 8'($urandom);
      do_load(base, cnt, $urandom_range(0, 50), 1'($urandom_range(0, 1)), 0);
      do_dump(base, cnt, $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
